// File: rtl/pattern_sequencer.sv
// pattern_sequencer: exhaustive pattern generator with MISR response compaction
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   start     - one-cycle request to run a full pattern pass
//   abort     - synchronous cancel of a running pass
//   golden    - expected signature, sampled as the pass completes
//   pattin    - pattern to the gate under test (bit NIN-1 is its first input)
//   pattout   - combinational response of the gate under test
//   busy      - pass running
//   done      - completed pass result held
//   pass      - final signature matched golden (valid with done)
//   signature - current MISR contents
module pattern_sequencer #(
   parameter int NIN = 2,
   parameter int SIGW = 8,
   parameter logic [SIGW-1:0] POLY = 8'h1D
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic [SIGW-1:0] golden,
   output logic [NIN-1:0]  pattin,
   input  logic            pattout,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [SIGW-1:0] signature
);
   typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;
   localparam logic [NIN-1:0] LAST = '1;
   state_t state, state_n;
   logic [NIN-1:0] pattin_n;
   logic [SIGW-1:0] sig_n, sig_step;
   logic pass_n;
   assign busy = (state == APPLY) || (state == CAPTURE);
   assign done = state == DONE;
   assign sig_step = {signature[SIGW-2:0], 1'b0} ^ (signature[SIGW-1] ? POLY : '0)
                   ^ {{(SIGW-1){1'b0}}, pattout};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         pattin <= '0;
         signature <= '0;
         pass <= 1'b0;
      end else begin
         state <= state_n;
         pattin <= pattin_n;
         signature <= sig_n;
         pass <= pass_n;
      end
   end
   always_comb begin
      state_n = state;
      pattin_n = pattin;
      sig_n = signature;
      pass_n = pass;
      case (state)
         IDLE, DONE: if (start) begin
            state_n = APPLY;
            pattin_n = '0;
            sig_n = '0;
            pass_n = 1'b0;
         end
         APPLY: state_n = CAPTURE;
         CAPTURE: begin
            sig_n = sig_step;
            if (pattin == LAST) begin
               state_n = DONE;
               pass_n = sig_step == golden;
            end else begin
               state_n = APPLY;
               pattin_n = pattin + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      // abort overrides whatever the running pass would have done this edge
      if (abort && busy) begin
         state_n = IDLE;
         pattin_n = '0;
         sig_n = '0;
         pass_n = 1'b0;
      end
   end
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed bench for pattern_sequencer driving a NOR gate model
module tb_pattern_sequencer;
   logic clk, rst, start, abort, pattout;
   logic [7:0] golden, signature;
   logic [1:0] pattin;
   logic busy, done, pass;
   int mode;
   int checks = 0;
   int errors = 0;

   pattern_sequencer #(.NIN(2), .SIGW(8), .POLY(8'h1D)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .golden(golden),
      .pattin(pattin), .pattout(pattout), .busy(busy), .done(done),
      .pass(pass), .signature(signature)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // gate under test: 0 = good NOR, 1 = output stuck-at-1, 2 = output stuck-at-0
   always_comb pattout = (mode == 0) ? ~(pattin[1] | pattin[0]) : (mode == 1);

   task automatic run_pass(input string name, input logic [31:0] exp, input logic [7:0] gold,
                           input logic exp_pass);
      golden = gold;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (pattin !== i[1:0] || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s apply%0d: pattin=%b busy=%b done=%b, want pattin=%b busy=1 done=0",
                     name, i, pattin, busy, done, i[1:0]);
         end
         @(negedge clk);
         checks++;
         if (pattin !== i[1:0] || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s capture%0d: pattin=%b busy=%b, want pattin=%b busy=1",
                     name, i, pattin, busy, i[1:0]);
         end
         @(negedge clk);
         checks++;
         if (signature !== exp[8*i+:8]) begin
            errors++;
            $display("FAIL %s sig%0d: got %h want %h", name, i, signature, exp[8*i+:8]);
         end
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || pass !== exp_pass || pattin !== 2'b11) begin
         errors++;
         $display("FAIL %s final: done=%b busy=%b pass=%b pattin=%b, want 1 0 %b 11",
                  name, done, busy, pass, pattin, exp_pass);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; golden = 8'h00; mode = 0;
      @(negedge clk);
      checks++;
      if ({busy, done, pass, pattin, signature} !== 13'd0) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b pass=%b pattin=%b sig=%h, want all 0",
                  busy, done, pass, pattin, signature);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || signature !== 8'h00) begin
         errors++;
         $display("FAIL reset_idle: busy=%b done=%b sig=%h, want 0 0 00", busy, done, signature);
      end
   endtask

   task automatic test_good_nor();
      mode = 0;
      run_pass("good_nor", 32'h08040201, 8'h08, 1'b1);
   endtask

   task automatic test_stuck1();
      mode = 1;
      run_pass("stuck1", 32'h0F070301, 8'h08, 1'b0);
   endtask

   task automatic test_stuck0();
      mode = 2;
      run_pass("stuck0", 32'h00000000, 8'h08, 1'b0);
      mode = 0;
   endtask

   task automatic test_done_hold();
      mode = 0;
      run_pass("hold_pre", 32'h08040201, 8'h08, 1'b1);
      golden = 8'h55;
      abort = 1'b1;
      repeat (3) @(negedge clk);
      abort = 1'b0;
      checks++;
      if (done !== 1'b1 || pass !== 1'b1 || signature !== 8'h08 || pattin !== 2'b11) begin
         errors++;
         $display("FAIL done_hold: done=%b pass=%b sig=%h pattin=%b, want 1 1 08 11",
                  done, pass, signature, pattin);
      end
   endtask

   task automatic test_start_abort_done();
      @(negedge clk) begin start = 1'b1; abort = 1'b1; end
      @(negedge clk) begin start = 1'b0; abort = 1'b0; end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || signature !== 8'h00 || pattin !== 2'b00) begin
         errors++;
         $display("FAIL start_wins: busy=%b done=%b pass=%b sig=%h pattin=%b, want 1 0 0 00 00",
                  busy, done, pass, signature, pattin);
      end
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_apply: busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_back_to_back();
      golden = 8'h08;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 2) start = 1'b1;
         if (k == 3) start = 1'b0;
         @(negedge clk);
         checks++;
         if (done !== (k == 8)) begin
            errors++;
            $display("FAIL restart_latency edge%0d: done=%b want %b", k, done, k == 8);
         end
      end
      checks++;
      if (signature !== 8'h08 || pass !== 1'b1) begin
         errors++;
         $display("FAIL restart_result: sig=%h pass=%b, want 08 1", signature, pass);
      end
   endtask

   task automatic test_abort();
      golden = 8'h08;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || pattin !== 2'b10 || signature !== 8'h02) begin
         errors++;
         $display("FAIL abort_pre: busy=%b pattin=%b sig=%h, want 1 10 02", busy, pattin, signature);
      end
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || signature !== 8'h00 || pattin !== 2'b00) begin
         errors++;
         $display("FAIL abort: busy=%b done=%b pass=%b sig=%h pattin=%b, want 0 0 0 00 00",
                  busy, done, pass, signature, pattin);
      end
      run_pass("after_abort", 32'h08040201, 8'h08, 1'b1);
   endtask

   task automatic test_async_reset();
      golden = 8'h08;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (signature !== 8'h01 || pattin !== 2'b01) begin
         errors++;
         $display("FAIL rst_pre: sig=%h pattin=%b, want 01 01", signature, pattin);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, pass, pattin, signature} !== 13'd0) begin
         errors++;
         $display("FAIL async_rst: busy=%b done=%b pass=%b pattin=%b sig=%h, want all 0",
                  busy, done, pass, pattin, signature);
      end
      #1 rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_stay_idle cyc%0d: busy=%b done=%b, want 0 0", k, busy, done);
         end
      end
   endtask

   initial begin
      test_reset();
      test_good_nor();
      test_stuck1();
      test_stuck0();
      test_done_hold();
      test_start_abort_done();
      test_back_to_back();
      test_abort();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
